// File: rtl/race_audio_arbiter.sv
// rtl/race_audio_arbiter.sv - shares the PWM audio pins between background music and three game-event tone effects
// Effects preempt music by fixed priority crash > finish > start; each plays four notes and is followed by a silent gap.
module race_audio_arbiter #(
  parameter int NOTE_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 5_000_000,
  parameter int TONE_SHIFT  = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_en,
  input  logic       finish_en,
  input  logic       crash_en,
  input  logic       pause,
  input  logic       music_pwm,
  input  logic       music_aud_on,
  output logic       pwm,
  output logic       aud_on,
  output logic [1:0] fx_src,
  output logic       fx_done
);
  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  localparam logic [24:0] NOTE_LAST = 25'(NOTE_CYCLES - 1);
  localparam logic [22:0] GAP_LAST  = 23'(GAP_CYCLES - 1);

  state_t      state;
  logic [1:0]  src;
  logic [1:0]  note_idx;
  logic [24:0] note_cnt;
  logic [22:0] gap_cnt;
  logic [16:0] tone_cnt;
  logic        pwm_fx;
  logic [3:1]  pending;
  logic [3:1]  prev;

  logic [3:1]  level;
  logic [3:1]  rise;
  logic [3:1]  eff;
  logic [1:0]  top;
  logic        rise_cur;
  logic        do_grant;
  logic [1:0]  grant_src;
  logic [3:1]  grant_mask;
  logic [16:0] hp;

  function automatic logic [16:0] tone_hp(input logic [1:0] s, input logic [1:0] n);
    logic [16:0] raw;
    logic [16:0] shifted;
    raw = 17'd0;
    case (s)
      2'd1: raw = (n == 2'd3) ? 17'd50000 : 17'd100000;
      2'd2: begin
        case (n)
          2'd0:    raw = 17'd80000;
          2'd1:    raw = 17'd60000;
          2'd2:    raw = 17'd50000;
          default: raw = 17'd40000;
        endcase
      end
      2'd3: begin
        case (n)
          2'd0:    raw = 17'd50000;
          2'd1:    raw = 17'd60000;
          2'd2:    raw = 17'd70000;
          default: raw = 17'd80000;
        endcase
      end
      default: raw = 17'd0;
    endcase
    shifted = raw >> TONE_SHIFT;
    tone_hp = (shifted == 17'd0) ? 17'd1 : shifted;
  endfunction

  assign level = {crash_en, finish_en, start_en};
  assign rise  = level & ~prev;
  // Same-cycle edges count as pending so a grant never waits an extra cycle.
  assign eff   = pending | rise;
  assign hp    = tone_hp(src, note_idx);

  always_comb begin
    top = 2'd0;
    if (eff[3])      top = 2'd3;
    else if (eff[2]) top = 2'd2;
    else if (eff[1]) top = 2'd1;

    rise_cur = (src == 2'd1 && rise[1]) || (src == 2'd2 && rise[2]) || (src == 2'd3 && rise[3]);

    do_grant  = 1'b0;
    grant_src = top;
    case (state)
      IDLE: do_grant = (top != 2'd0);
      PLAY: begin
        // Higher priority preempts; a re-edge of the playing source restarts it.
        do_grant  = (top > src) || rise_cur;
        grant_src = (top > src) ? top : src;
      end
      default: do_grant = (gap_cnt == GAP_LAST) && (top != 2'd0);
    endcase

    grant_mask = {grant_src == 2'd3, grant_src == 2'd2, grant_src == 2'd1};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      src      <= 2'd0;
      note_idx <= 2'd0;
      note_cnt <= 25'd0;
      gap_cnt  <= 23'd0;
      tone_cnt <= 17'd0;
      pwm_fx   <= 1'b0;
      pending  <= 3'b000;
      prev     <= level;
      pwm      <= 1'b0;
      aud_on   <= 1'b0;
      fx_src   <= 2'd0;
      fx_done  <= 1'b0;
    end else begin
      prev    <= level;
      fx_done <= 1'b0;
      pending <= do_grant ? (eff & ~grant_mask) : eff;

      case (state)
        IDLE: begin
          pwm    <= music_pwm & ~pause;
          aud_on <= music_aud_on & ~pause;
          fx_src <= 2'd0;
        end
        PLAY: begin
          pwm    <= pwm_fx;
          aud_on <= 1'b1;
          fx_src <= src;
        end
        default: begin
          pwm    <= 1'b0;
          aud_on <= 1'b0;
          fx_src <= 2'd0;
        end
      endcase

      if (do_grant) begin
        state    <= PLAY;
        src      <= grant_src;
        note_idx <= 2'd0;
        note_cnt <= 25'd0;
        tone_cnt <= 17'd0;
        pwm_fx   <= 1'b0;
      end else begin
        case (state)
          PLAY: begin
            if (note_cnt == NOTE_LAST) begin
              note_cnt <= 25'd0;
              tone_cnt <= 17'd0;
              pwm_fx   <= 1'b0;
              if (note_idx == 2'd3) begin
                fx_done <= 1'b1;
                state   <= GAP;
                gap_cnt <= 23'd0;
              end else begin
                note_idx <= note_idx + 2'd1;
              end
            end else begin
              note_cnt <= note_cnt + 25'd1;
              if (tone_cnt == hp - 17'd1) begin
                tone_cnt <= 17'd0;
                pwm_fx   <= ~pwm_fx;
              end else begin
                tone_cnt <= tone_cnt + 17'd1;
              end
            end
          end
          GAP: begin
            if (gap_cnt == GAP_LAST) state <= IDLE;
            else gap_cnt <= gap_cnt + 23'd1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_race_audio_arbiter.sv
// tb/tb_race_audio_arbiter.sv - scoreboard bench for race_audio_arbiter with an arithmetic reference model
// Directed scenarios first, then randomized effect edges, pause, music and occasional resets.
module tb_race_audio_arbiter;
  localparam int NOTE  = 64;
  localparam int GAP   = 16;
  localparam int SHIFT = 12;
  localparam int S_IDLE = 0;
  localparam int S_PLAY = 1;
  localparam int S_GAP  = 2;

  typedef struct packed {
    logic       pwm;
    logic       aud;
    logic [1:0] src;
    logic       done;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_en, finish_en, crash_en;
  logic       pause, music_pwm, music_aud_on;
  logic       pwm, aud_on, fx_done;
  logic [1:0] fx_src;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];
  int   done_q[$];

  int m_state = S_IDLE;
  int m_src = 0;
  int m_e = 0;
  int m_g = 0;
  int prv [1:3];
  int pend [1:3];

  race_audio_arbiter #(
    .NOTE_CYCLES(NOTE),
    .GAP_CYCLES (GAP),
    .TONE_SHIFT (SHIFT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_en    (start_en),
    .finish_en   (finish_en),
    .crash_en    (crash_en),
    .pause       (pause),
    .music_pwm   (music_pwm),
    .music_aud_on(music_aud_on),
    .pwm         (pwm),
    .aud_on      (aud_on),
    .fx_src      (fx_src),
    .fx_done     (fx_done)
  );

  always #5 clk = ~clk;

  function automatic int model_hp(input int s, input int n);
    int raw;
    case (s)
      1: raw = (n == 3) ? 50000 : 100000;
      2: begin
        case (n)
          0: raw = 80000;
          1: raw = 60000;
          2: raw = 50000;
          default: raw = 40000;
        endcase
      end
      default: begin
        case (n)
          0: raw = 50000;
          1: raw = 60000;
          2: raw = 70000;
          default: raw = 80000;
        endcase
      end
    endcase
    raw = raw >> SHIFT;
    if (raw < 1) raw = 1;
    return raw;
  endfunction

  // Effect waveform as a function of cycles elapsed since the grant.
  function automatic logic fx_level(input int s, input int e);
    int n, ph;
    n  = e / NOTE;
    ph = e % NOTE;
    return ((ph / model_hp(s, n)) % 2) == 1;
  endfunction

  always @(posedge clk) begin : model
    exp_t x;
    int lv [1:3];
    int r [1:3];
    int eff [1:3];
    int h, g;
    lv[1] = int'(start_en);
    lv[2] = int'(finish_en);
    lv[3] = int'(crash_en);
    x = '0;
    g = 0;
    if (reset) begin
      m_state = S_IDLE;
      m_src = 0;
      m_e = 0;
      m_g = 0;
      for (int i = 1; i <= 3; i++) pend[i] = 0;
    end else begin
      case (m_state)
        S_IDLE: begin
          x.pwm = music_pwm & ~pause;
          x.aud = music_aud_on & ~pause;
        end
        S_PLAY: begin
          x.pwm = fx_level(m_src, m_e);
          x.aud = 1'b1;
          x.src = 2'(m_src);
        end
        default: ;
      endcase
      h = 0;
      for (int i = 1; i <= 3; i++) begin
        r[i]   = (lv[i] != 0 && prv[i] == 0) ? 1 : 0;
        eff[i] = (pend[i] != 0 || r[i] != 0) ? 1 : 0;
        if (eff[i] != 0) h = i;
      end
      case (m_state)
        S_IDLE: g = h;
        S_PLAY: begin
          if (h > m_src) g = h;
          else if (r[m_src] != 0) g = m_src;
          else if (m_e == 4 * NOTE - 1) begin
            x.done = 1'b1;
            done_q.push_back(m_src);
            m_state = S_GAP;
            m_g = 0;
          end else m_e++;
        end
        default: begin
          if (m_g == GAP - 1) begin
            g = h;
            if (h == 0) m_state = S_IDLE;
          end else m_g++;
        end
      endcase
      if (g != 0) begin
        m_state = S_PLAY;
        m_src = g;
        m_e = 0;
        eff[g] = 0;
      end
      for (int i = 1; i <= 3; i++) pend[i] = eff[i];
    end
    for (int i = 1; i <= 3; i++) prv[i] = lv[i];
    exp_q.push_back(x);
  end

  always @(negedge clk) begin : monitor
    exp_t w, a;
    int s;
    if (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      a = {pwm, aud_on, fx_src, fx_done};
      checks++;
      if (a !== w) begin
        errors++;
        $display("FAIL outputs t=%0t: got pwm=%b aud_on=%b fx_src=%0d fx_done=%b, want pwm=%b aud_on=%b fx_src=%0d fx_done=%b",
                 $time, a.pwm, a.aud, a.src, a.done, w.pwm, w.aud, w.src, w.done);
      end
    end
    if (fx_done === 1'b1) begin
      checks++;
      if (done_q.size() == 0) begin
        errors++;
        $display("FAIL fx_done_unexpected t=%0t: got fx_done=1 fx_src=%0d, want no completion", $time, fx_src);
      end else begin
        s = done_q.pop_front();
        if (int'(fx_src) != s) begin
          errors++;
          $display("FAIL fx_done_src t=%0t: got fx_src=%0d, want %0d", $time, fx_src, s);
        end
      end
    end
  end

  task automatic run(input int n);
    repeat (n) begin
      music_pwm = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
  endtask

  task automatic set_en(input logic s, input logic f, input logic c);
    start_en = s;
    finish_en = f;
    crash_en = c;
  endtask

  initial begin
    reset = 1'b1;
    set_en(0, 0, 0);
    pause = 1'b0;
    music_pwm = 1'b0;
    music_aud_on = 1'b1;
    run(3);
    reset = 1'b0;

    // music passthrough, then paused
    run(20);
    pause = 1'b1;
    run(10);
    pause = 1'b0;
    run(5);

    // single crash effect through its gap back to music
    set_en(0, 0, 1);
    run(300);
    set_en(0, 0, 0);
    run(10);

    // start preempted by finish 30 cycles in
    set_en(1, 0, 0);
    run(30);
    set_en(1, 1, 0);
    run(350);
    set_en(0, 0, 0);
    run(20);

    // lower priority queued behind crash
    set_en(0, 0, 1);
    run(50);
    set_en(1, 0, 1);
    run(700);
    set_en(0, 0, 0);
    run(20);

    // all three edges in one cycle
    set_en(1, 1, 1);
    run(1000);
    set_en(0, 0, 0);
    run(10);

    // reset during crash note 2 with crash_en held high
    set_en(0, 0, 1);
    run(150);
    reset = 1'b1;
    run(3);
    reset = 1'b0;
    run(50);
    set_en(0, 0, 0);
    run(10);

    // re-edge of the playing source restarts it
    set_en(0, 1, 0);
    run(100);
    set_en(0, 0, 0);
    run(2);
    set_en(0, 1, 0);
    run(320);
    set_en(0, 0, 0);
    run(10);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 59) == 0) start_en = ~start_en;
      if ($urandom_range(0, 79) == 0) finish_en = ~finish_en;
      if ($urandom_range(0, 99) == 0) crash_en = ~crash_en;
      if ($urandom_range(0, 79) == 0) pause = ~pause;
      if ($urandom_range(0, 29) == 0) music_aud_on = ~music_aud_on;
      reset = ($urandom_range(0, 799) == 0);
      run(1);
    end
    reset = 1'b0;
    set_en(0, 0, 0);
    run(1200);

    #2;
    checks++;
    if (done_q.size() != 0) begin
      errors++;
      $display("FAIL fx_done_missing: got %0d completions outstanding, want 0", done_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
